// File: rtl/reg_file_init_if.sv
// Register-file bus: two combinational read ports, one write port, and the
// status outputs (Ready, Wr_Drop).
interface reg_file_init_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Read_Reg_1;
  logic [ADDR_W-1:0] Read_Reg_2;
  logic [DATA_W-1:0] Read_Data_1;
  logic [DATA_W-1:0] Read_Data_2;
  logic [ADDR_W-1:0] Write_Reg;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;
  logic              Ready;
  logic              Wr_Drop;

  modport master (
    output Read_Reg_1, Read_Reg_2, Write_Reg, Write_Data, RegWrite,
    input  Read_Data_1, Read_Data_2, Ready, Wr_Drop
  );

  modport slave (
    input  Read_Reg_1, Read_Reg_2, Write_Reg, Write_Data, RegWrite,
    output Read_Data_1, Read_Data_2, Ready, Wr_Drop
  );
endinterface

// File: rtl/reg_file_init.sv
// Parametrised register file. After reset it clears itself one entry per
// cycle, then accepts writes; reads are combinational with optional bypass.
//
// state | meaning
// INIT  | sweeping zeros into storage, reads forced to 0, writes dropped
// RUN   | normal operation, Ready high
module reg_file_init #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  reg_file_init_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_ptr;
  logic [ADDR_W-1:0] w_init_ptr_nxt;
  logic              r_ready;
  logic              w_ready_nxt;
  logic              r_wr_drop;
  logic              w_wr_drop_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
      r_ready    <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
      r_ready    <= w_ready_nxt;
      r_wr_drop  <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_ready_nxt    = r_ready;
    w_wr_drop_nxt  = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = bus.Write_Reg;
    w_mem_data     = bus.Write_Data;
    case (r_state)
      INIT: begin
        w_mem_we       = 1'b1;
        w_mem_addr     = r_init_ptr;
        w_mem_data     = '0;
        w_init_ptr_nxt = r_init_ptr + 1'b1;
        w_wr_drop_nxt  = bus.RegWrite;
        if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = RUN;
          w_ready_nxt = 1'b1;
        end
      end
      RUN: begin
        w_ready_nxt = 1'b1;
        // Writes to the hardwired zero register are a legal no-op, not a drop.
        if (bus.RegWrite && !(ZERO_REG != 0 && bus.Write_Reg == '0)) begin
          w_mem_we = 1'b1;
        end
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  // Storage has no reset of its own; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] i_addr,
    input logic [DATA_W-1:0] i_stored
  );
    logic [DATA_W-1:0] w_val;
    if (r_state == INIT) begin
      w_val = '0;
    end else if (ZERO_REG != 0 && i_addr == '0) begin
      w_val = '0;
    end else if (BYPASS != 0 && bus.RegWrite && i_addr == bus.Write_Reg) begin
      w_val = bus.Write_Data;
    end else begin
      w_val = i_stored;
    end
    return w_val;
  endfunction

  assign bus.Read_Data_1 = f_read(bus.Read_Reg_1, r_mem[bus.Read_Reg_1]);
  assign bus.Read_Data_2 = f_read(bus.Read_Reg_2, r_mem[bus.Read_Reg_2]);
  assign bus.Ready       = r_ready;
  assign bus.Wr_Drop     = r_wr_drop;
endmodule

// File: tb/tb_reg_file_init.sv
// Bench for reg_file_init: a bypassing and a non-bypassing instance share
// stimulus and are checked every cycle against a behavioural model.
module tb_reg_file_init;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_init_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  reg_file_init_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  reg_file_init #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  reg_file_init #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  assign bus_b.Read_Reg_1 = bus_a.Read_Reg_1;
  assign bus_b.Read_Reg_2 = bus_a.Read_Reg_2;
  assign bus_b.Write_Reg  = bus_a.Write_Reg;
  assign bus_b.Write_Data = bus_a.Write_Data;
  assign bus_b.RegWrite   = bus_a.RegWrite;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset release, plain array of register contents.
  logic [31:0] m_mem [32];
  int          m_edges = 0;
  bit          m_ready = 1'b0;
  bit          m_drop  = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_drop  = 1'b0;
      m_edges = 0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_mem[m_edges] = 32'h0;
        m_drop  = bus_a.RegWrite;
        m_edges = m_edges + 1;
        if (m_edges == 32) m_ready = 1'b1;
      end else begin
        m_drop = 1'b0;
        if (bus_a.RegWrite && bus_a.Write_Reg != 5'd0)
          m_mem[bus_a.Write_Reg] = bus_a.Write_Data;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (!m_ready) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && bus_a.RegWrite && a == bus_a.Write_Reg) return bus_a.Write_Data;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready_a", {31'b0, bus_a.Ready},   {31'b0, m_ready});
      chk("ready_b", {31'b0, bus_b.Ready},   {31'b0, m_ready});
      chk("drop_a",  {31'b0, bus_a.Wr_Drop}, {31'b0, m_drop});
      chk("drop_b",  {31'b0, bus_b.Wr_Drop}, {31'b0, m_drop});
      chk("rd1_a", bus_a.Read_Data_1, exp_rd(1'b1, bus_a.Read_Reg_1));
      chk("rd2_a", bus_a.Read_Data_2, exp_rd(1'b1, bus_a.Read_Reg_2));
      chk("rd1_b", bus_b.Read_Data_1, exp_rd(1'b0, bus_a.Read_Reg_1));
      chk("rd2_b", bus_b.Read_Data_2, exp_rd(1'b0, bus_a.Read_Reg_2));
    end
  end

  task automatic wait_ready(input string name, input int exp_edges);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.Ready) begin
        k = i;
        break;
      end
    end
    chk(name, k, exp_edges);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus_a.RegWrite   = 1'b0;
    bus_a.Write_Reg  = 5'd0;
    bus_a.Write_Data = 32'h0;
    bus_a.Read_Reg_1 = 5'd0;
    bus_a.Read_Reg_2 = 5'd0;

    // Reset for two edges, then Ready must appear on edge 32.
    step();
    step();
    chk("rst_ready", {31'b0, bus_a.Ready}, 32'h0);
    chk("rst_rd1", bus_a.Read_Data_1, 32'h0);
    rst = 1'b0;
    wait_ready("ready_edge_first", 32);
    for (int i = 0; i < 32; i++) begin
      bus_a.Read_Reg_1 = 5'(i);
      bus_a.Read_Reg_2 = 5'(31 - i);
      @(negedge clk);
      chk("sweep_rd1_b", bus_b.Read_Data_1, 32'h0);
    end

    // Write r5: bypass instance sees it now, the other after the edge.
    @(posedge clk); #1;
    bus_a.RegWrite   = 1'b1;
    bus_a.Write_Reg  = 5'd5;
    bus_a.Write_Data = 32'hDEADBEEF;
    bus_a.Read_Reg_1 = 5'd5;
    @(negedge clk);
    chk("r5_bypass_same", bus_a.Read_Data_1, 32'hDEADBEEF);
    chk("r5_nobypass_old", bus_b.Read_Data_1, 32'h0);
    step();
    bus_a.RegWrite = 1'b0;
    @(negedge clk);
    chk("r5_nobypass_new", bus_b.Read_Data_1, 32'hDEADBEEF);

    // Zero register write is a silent no-op.
    @(posedge clk); #1;
    bus_a.RegWrite   = 1'b1;
    bus_a.Write_Reg  = 5'd0;
    bus_a.Write_Data = 32'h12345678;
    bus_a.Read_Reg_1 = 5'd0;
    bus_a.Read_Reg_2 = 5'd0;
    @(negedge clk);
    chk("r0_rd1_same", bus_a.Read_Data_1, 32'h0);
    chk("r0_rd2_same", bus_a.Read_Data_2, 32'h0);
    step();
    bus_a.RegWrite = 1'b0;
    chk("r0_drop", {31'b0, bus_a.Wr_Drop}, 32'h0);
    @(negedge clk);
    chk("r0_rd1_next", bus_b.Read_Data_1, 32'h0);

    // Both ports and the write port on r9.
    bus_a.RegWrite   = 1'b1;
    bus_a.Write_Reg  = 5'd9;
    bus_a.Write_Data = 32'h0000FFFF;
    bus_a.Read_Reg_1 = 5'd9;
    bus_a.Read_Reg_2 = 5'd9;
    @(negedge clk);
    chk("r9_rd1_byp", bus_a.Read_Data_1, 32'h0000FFFF);
    chk("r9_rd2_byp", bus_a.Read_Data_2, 32'h0000FFFF);
    step();
    bus_a.RegWrite = 1'b0;
    @(negedge clk);
    chk("r9_stored", bus_b.Read_Data_2, 32'h0000FFFF);

    // Write attempted on INIT edge 3 is dropped with a one-cycle pulse.
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    bus_a.RegWrite   = 1'b1;
    bus_a.Write_Reg  = 5'd7;
    bus_a.Write_Data = 32'hA5A5A5A5;
    step();
    bus_a.RegWrite = 1'b0;
    chk("drop_pulse_hi", {31'b0, bus_a.Wr_Drop}, 32'h1);
    step();
    chk("drop_pulse_lo", {31'b0, bus_a.Wr_Drop}, 32'h0);
    wait_ready("ready_edge_drop", 28);
    bus_a.Read_Reg_1 = 5'd7;
    bus_a.Read_Reg_2 = 5'd7;
    @(negedge clk);
    chk("r7_after_drop", bus_b.Read_Data_1, 32'h0);

    // Fill r1..r31 with their index, then reset mid-run (with a write pending).
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) begin
      bus_a.RegWrite   = 1'b1;
      bus_a.Write_Reg  = 5'(i);
      bus_a.Write_Data = 32'(i);
      step();
    end
    bus_a.RegWrite   = 1'b0;
    bus_a.Read_Reg_1 = 5'd17;
    bus_a.Read_Reg_2 = 5'd31;
    #1;
    chk("fill_r17", bus_b.Read_Data_1, 32'd17);
    chk("fill_r31", bus_b.Read_Data_2, 32'd31);
    rst              = 1'b1;
    bus_a.RegWrite   = 1'b1;
    bus_a.Write_Reg  = 5'd3;
    bus_a.Write_Data = 32'h77;
    step();
    rst            = 1'b0;
    bus_a.RegWrite = 1'b0;
    chk("midrst_ready", {31'b0, bus_a.Ready}, 32'h0);
    chk("midrst_drop", {31'b0, bus_a.Wr_Drop}, 32'h0);
    chk("midrst_rd1", bus_b.Read_Data_1, 32'h0);
    wait_ready("ready_edge_midrst", 32);
    for (int i = 0; i < 32; i++) begin
      bus_a.Read_Reg_1 = 5'(i);
      bus_a.Read_Reg_2 = 5'(i);
      @(negedge clk);
      chk("cleared_rd1_b", bus_b.Read_Data_1, 32'h0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
